// File: rtl/uart_pkg.sv
// Constants and types shared by the UART transmit-side blocks.
package uart_pkg;
  localparam int LEN_W       = 2;
  localparam int BYTE_W      = 8;
  localparam int GAP_W       = 18;
  localparam int GAP_DEFAULT = 166576;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [LEN_W-1:0]    len;
    logic [4*BYTE_W-1:0] data;
  } frame_t;
endpackage

// File: rtl/tx_gap_timer.sv
// Inter-byte gap timer: reloads on every strobe, saturates at GAP.
module tx_gap_timer
  import uart_pkg::*;
#(
  parameter int GAP = GAP_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);
  localparam logic [GAP_W-1:0] GAP_V = GAP_W'(GAP);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  // Loaded with 1 on the strobe decision so it reads GAP exactly GAP-1
  // cycles after the strobe, which is the decision cycle for the next one.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = GAP_W'(1);
    else if (cnt_q < GAP_V)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == GAP_V);
endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a byte serializer with paced strobes.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int GAP = GAP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic [31:0]       data0,
  input  logic [31:0]       data1,
  input  logic              tx_busy,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              owner,
  output logic              busy
);
  tx_state_e         state_q, state_d;
  frame_t            frame_q, frame_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] txd_q, txd_d;
  logic last_q, last_d, owner_q, owner_d, fin_q, fin_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic txr_q, txr_d, busy_q, busy_d;
  logic sel, expired;

  tx_gap_timer #(.GAP(GAP)) u_gap (
    .clk       (clk),
    .rst       (rst),
    .load_i    (txr_d),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    last_d  = last_q;
    owner_d = owner_q;
    fin_d   = fin_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    txr_d   = 1'b0;
    // On a tie the requester that was not served last wins.
    sel     = (req0 & req1) ? ~last_q : req1;
    case (state_q)
      ST_IDLE: if (req0 | req1) begin
        state_d      = ST_SEND;
        last_d       = sel;
        owner_d      = sel;
        frame_d.len  = sel ? len1 : len0;
        frame_d.data = sel ? data1 : data0;
        idx_d        = '0;
        fin_d        = 1'b0;
        gnt0_d       = ~sel;
        gnt1_d       = sel;
      end
      ST_SEND: begin
        if (txr_q && fin_q) begin
          state_d = ST_DONE;
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else if (!fin_q && !txr_q && !tx_busy && (idx_q == '0 || expired)) begin
          // First byte ignores the gap; later bytes wait for the timer.
          txr_d = 1'b1;
          txd_d = frame_q.data[{idx_q, 3'b000} +: BYTE_W];
          idx_d = idx_q + 1'b1;
          fin_d = (idx_q == frame_q.len);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      txd_q   <= '0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      fin_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      txr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      fin_q   <= fin_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      txr_q   <= txr_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign tx_ready = txr_q;
  assign tx_data  = txd_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed vectors plus random-traffic invariants for uart_tx_arb with GAP=4.
module tb_uart_tx_arb;
  logic        clk = 1'b0, rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, tx_busy = 1'b0;
  logic [1:0]  len0 = '0, len1 = '0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, done0, done1, tx_ready, owner, busy;
  logic [7:0]  tx_data;
  logic [6:0]  outs;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          drained;

  uart_tx_arb #(.GAP(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .tx_busy(tx_busy), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .tx_ready(tx_ready), .tx_data(tx_data),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;
  assign outs = {gnt0, gnt1, done0, done1, tx_ready, busy, owner};

  typedef struct {
    logic        req0;
    logic [1:0]  len0;
    logic [31:0] data0;
    logic [6:0]  exp;
    logic [7:0]  exp_d;
  } vec_t;
  vec_t vt[32];

  function automatic logic [6:0] pk(input logic g0, g1, d0, d1, tr, b, o);
    return {g0, g1, d0, d1, tr, b, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-traffic invariants
  logic [1:0] len0_s, len1_s;
  bit prev_txr = 1'b0;
  int since = 100, nstb = 0, frame_len = 0;
  always @(posedge clk) begin
    len0_s = len0;
    len1_s = len1;
  end
  always @(negedge clk) if (mon_en) begin
    if (gnt0 || gnt1) begin
      frame_len = gnt1 ? int'(len1_s) : int'(len0_s);
      nstb = 0;
    end
    checks++;
    if (tx_ready && prev_txr) begin errors++; $display("FAIL consec_txr: got 1,1 expected not both"); end
    checks++;
    if ((gnt0 && gnt1) || (done0 && done1)) begin
      errors++; $display("FAIL onehot: gnt=%b%b done=%b%b expected one-hot", gnt0, gnt1, done0, done1);
    end
    if (tx_ready) begin
      if (nstb > 0) begin
        checks++;
        if (since < 4) begin errors++; $display("FAIL spacing: got %0d expected >=4", since); end
      end
      nstb++;
      since = 0;
    end
    since++;
    if (done0 || done1) begin
      checks++;
      if (nstb != frame_len + 1) begin
        errors++; $display("FAIL strobes_per_frame: got %0d expected %0d", nstb, frame_len + 1);
      end
    end
    prev_txr = tx_ready;
  end

  initial begin
    // Rows 0-15: single frame; rows 16-31: same frame with inputs changed after grant.
    for (int i = 0; i < 32; i++) begin
      int k;
      bit second;
      k = i % 16;
      second = (i >= 16);
      vt[i].req0  = second ? (k == 0) : (k <= 14);
      vt[i].len0  = (second && k > 0) ? 2'd1 : 2'd3;
      vt[i].data0 = (second && k > 0) ? 32'hDEADBEEF : 32'h44332211;
      vt[i].exp   = pk(k == 0, 1'b0, k == 14, 1'b0, (k % 4 == 1) && k <= 13, k <= 14, 1'b0);
      vt[i].exp_d = (k == 1) ? 8'h11 : (k == 5) ? 8'h22 : (k == 9) ? 8'h33 : (k == 13) ? 8'h44 : 8'h00;
    end

    #2;
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_data", 32'(tx_data), 32'd0);
    tick(); tick();
    rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      req0 = vt[i].req0; len0 = vt[i].len0; data0 = vt[i].data0;
      tick();
      chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vt[i].exp));
      if (vt[i].exp[2]) chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vt[i].exp_d));
    end

    // Tie from reset release: 0 wins first, then strict alternation.
    #2; rst = 1'b0; #1;
    chk("rst2_outs", 32'(outs), 32'd0);
    req0 = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0;
    data0 = 32'h000000A0; data1 = 32'h000000B1;
    tick(); tick();
    rst = 1'b1;
    for (int k = 0; k < 16; k++) begin
      int m;
      m = k % 8;
      tick();
      chk($sformatf("tie%0d_outs", k), 32'(outs),
          32'(pk(m == 0, m == 4, m == 2, m == 6, m % 4 == 1, m % 4 != 3, m >= 4)));
      if (m % 4 == 1) chk($sformatf("tie%0d_data", k), 32'(tx_data), (m == 1) ? 32'hA0 : 32'hB1);
      if (k == 15) begin req0 = 1'b0; req1 = 1'b0; end
    end

    // Backpressure across the second byte's gap expiry.
    tick(); tick();
    req0 = 1'b1; len0 = 2'd2; data0 = 32'h00CCBBAA;
    for (int k = 0; k < 22; k++) begin
      tick();
      chk($sformatf("bp%0d_outs", k), 32'(outs),
          32'(pk(k == 0, 1'b0, k == 20, 1'b0, k == 1 || k == 15 || k == 19, k <= 20, 1'b0)));
      if (k == 1)  chk("bp_data0", 32'(tx_data), 32'hAA);
      if (k == 15) chk("bp_data1", 32'(tx_data), 32'hBB);
      if (k == 19) chk("bp_data2", 32'(tx_data), 32'hCC);
      if (k == 0) req0 = 1'b0;
      tx_busy = (k >= 4 && k <= 13);
    end

    // Reset in the middle of a frame, then requester 1 alone.
    tick();
    req0 = 1'b1; len0 = 2'd3; data0 = 32'h99887766;
    tick();
    chk("rm_gnt", 32'(outs), 32'(pk(1, 0, 0, 0, 0, 1, 0)));
    req0 = 1'b0;
    tick();
    chk("rm_stb", 32'(outs), 32'(pk(0, 0, 0, 0, 1, 1, 0)));
    chk("rm_stb_data", 32'(tx_data), 32'h66);
    tick();
    #2; rst = 1'b0; #1;
    chk("rm_async_outs", 32'(outs), 32'd0);
    chk("rm_async_data", 32'(tx_data), 32'd0);
    req1 = 1'b1; len1 = 2'd1; data1 = 32'h00005566;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rm_hold%0d", k), 32'(outs), 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rm%0d_outs", k), 32'(outs),
          32'(pk(1'b0, k == 0, 1'b0, k == 6, k == 1 || k == 5, k <= 6, 1'b1)));
      if (k == 1) chk("rm_data0", 32'(tx_data), 32'h66);
      if (k == 5) chk("rm_data1", 32'(tx_data), 32'h55);
      if (k == 0) req1 = 1'b0;
    end

    // Random traffic under the invariant monitor.
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      tick();
      req0    = ($urandom_range(0, 3) != 0);
      req1    = ($urandom_range(0, 3) != 0);
      len0    = 2'($urandom_range(0, 3));
      len1    = 2'($urandom_range(0, 3));
      data0   = $urandom;
      data1   = $urandom;
      tx_busy = ($urandom_range(0, 4) == 0);
    end
    req0 = 1'b0; req1 = 1'b0; tx_busy = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 200 && !drained; c++) begin
      tick();
      if (!busy) drained = 1'b1;
    end
    chk("drain_timeout", 32'(drained), 32'd1);
    tick();
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
